// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap controller: reads, trap decision and targets are combinational, state commits at clk.
// No backpressure: every CSR access, trap and MRET completes in the cycle it is presented.
module csr_trap_unit #(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter logic [31:0] MTVEC_RESET   = 32'h0000_0000,
  parameter int          HART_ID       = 0,
  localparam int         LW            = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [11:0]   csr_addr,
  input  logic [31:0]   csr_wdata,
  input  logic          csr_wen,
  input  logic [2:0]    csr_op,
  output logic [31:0]   csr_rdata,
  output logic          csr_illegal,
  input  logic          irq_software,
  input  logic          irq_timer,
  input  logic          irq_external,
  input  logic [LW-1:0] irq_local,
  input  logic          exc_valid,
  input  logic [3:0]    exc_cause,
  input  logic [31:0]   exc_tval,
  input  logic [31:0]   current_pc,
  input  logic          instr_retire,
  input  logic          mret_exec,
  output logic          trap_taken,
  output logic [31:0]   trap_pc,
  output logic [31:0]   mret_pc,
  output logic          irq_pending
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [31:0] MISA_VAL   = 32'h4000_0100;
  localparam logic [31:0] LOCAL_MASK = 32'(((64'd1 << NUM_LOCAL_IRQ) - 64'd1) << 16);
  localparam logic [31:0] MIE_MASK   = 32'h0000_0888 | LOCAL_MASK;

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;

  logic [31:0] mip_val, pending, mstatus_rd, tvec_base, wr_val;
  logic [4:0]  irq_code;
  logic        known, read_only, wr_req, wr_en, irq_take;

  always_comb begin
    mip_val     = '0;
    mip_val[3]  = irq_software;
    mip_val[7]  = irq_timer;
    mip_val[11] = irq_external;
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip_val[16+i] = irq_local[i];
  end

  assign pending     = mip_val & mie_q;
  assign irq_pending = |pending;

  // Later assignments override earlier ones, so the last test has highest priority.
  always_comb begin
    irq_code = 5'd0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
      if (pending[16+i]) irq_code = 5'(16 + i);
    end
    if (pending[7])  irq_code = 5'd7;
    if (pending[3])  irq_code = 5'd3;
    if (pending[11]) irq_code = 5'd11;
  end

  assign irq_take   = mstatus_mie & irq_pending;
  assign trap_taken = exc_valid | irq_take;
  assign tvec_base  = {mtvec_q[31:2], 2'b00};
  assign trap_pc    = (!exc_valid && mtvec_q[0]) ? tvec_base + {25'd0, irq_code, 2'b00}
                                                 : tvec_base;
  assign mret_pc    = mepc_q;
  assign mstatus_rd = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};

  always_comb begin
    csr_rdata = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      A_MSTATUS:   csr_rdata = mstatus_rd;
      A_MISA:      begin csr_rdata = MISA_VAL; read_only = 1'b1; end
      A_MIE:       csr_rdata = mie_q;
      A_MTVEC:     csr_rdata = mtvec_q;
      A_MSCRATCH:  csr_rdata = mscratch_q;
      A_MEPC:      csr_rdata = mepc_q;
      A_MCAUSE:    csr_rdata = mcause_q;
      A_MTVAL:     csr_rdata = mtval_q;
      A_MIP:       begin csr_rdata = mip_val; read_only = 1'b1; end
      A_MCYCLE:    csr_rdata = mcycle_q[31:0];
      A_MCYCLEH:   csr_rdata = mcycle_q[63:32];
      A_MINSTRET:  csr_rdata = minstret_q[31:0];
      A_MINSTRETH: csr_rdata = minstret_q[63:32];
      A_MHARTID:   begin csr_rdata = 32'(HART_ID); read_only = 1'b1; end
      default:     known = 1'b0;
    endcase
  end

  always_comb begin
    case (csr_op)
      3'b010:  wr_val = csr_rdata | csr_wdata;
      3'b011:  wr_val = csr_rdata & ~csr_wdata;
      default: wr_val = csr_wdata;
    endcase
  end

  assign wr_req      = csr_wen & ((csr_op == 3'b001) | (csr_op == 3'b010) | (csr_op == 3'b011));
  assign csr_illegal = ~known | (read_only & wr_req);
  // A trap in the same cycle discards the CSR write.
  assign wr_en       = wr_req & known & ~read_only & ~trap_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RESET & 32'hFFFF_FFFD;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
    end else begin
      mcycle_q   <= mcycle_q + 64'd1;
      minstret_q <= minstret_q + {63'd0, instr_retire};
      if (wr_en) begin
        case (csr_addr)
          A_MSTATUS:   begin mstatus_mie <= wr_val[3]; mstatus_mpie <= wr_val[7]; end
          A_MIE:       mie_q      <= wr_val & MIE_MASK;
          A_MTVEC:     mtvec_q    <= wr_val & 32'hFFFF_FFFD;
          A_MSCRATCH:  mscratch_q <= wr_val;
          A_MEPC:      mepc_q     <= wr_val & 32'hFFFF_FFFC;
          A_MCAUSE:    mcause_q   <= wr_val;
          A_MTVAL:     mtval_q    <= wr_val;
          A_MCYCLE:    mcycle_q   <= {mcycle_q[63:32], wr_val};
          A_MCYCLEH:   mcycle_q   <= {wr_val, mcycle_q[31:0]};
          A_MINSTRET:  minstret_q <= {minstret_q[63:32], wr_val};
          A_MINSTRETH: minstret_q <= {wr_val, minstret_q[31:0]};
          default: ;
        endcase
      end
      if (trap_taken) begin
        mepc_q       <= current_pc & 32'hFFFF_FFFC;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        mcause_q     <= exc_valid ? {28'd0, exc_cause} : {1'b1, 26'd0, irq_code};
        mtval_q      <= exc_valid ? exc_tval : 32'd0;
      end else if (mret_exec) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios plus randomized traffic against a visible-value reference model.
module tb_csr_trap_unit;
  localparam int          NL      = 4;
  localparam logic [31:0] MT_RST  = 32'h0000_0400;
  localparam int          HID     = 3;
  localparam logic [31:0] MIE_MSK = 32'h000F_0888;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, exc_tval, current_pc, trap_pc, mret_pc;
  logic        csr_wen, csr_illegal, irq_software, irq_timer, irq_external;
  logic [2:0]  csr_op;
  logic [NL-1:0] irq_local;
  logic        exc_valid, instr_retire, mret_exec, trap_taken, irq_pending;
  logic [3:0]  exc_cause;

  int n_checks = 0;
  int n_fail   = 0;

  always #50 clk = ~clk;

  csr_trap_unit #(.NUM_LOCAL_IRQ(NL), .MTVEC_RESET(MT_RST), .HART_ID(HID)) dut (
    .clk(clk), .reset(reset), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .csr_op(csr_op), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .irq_software(irq_software), .irq_timer(irq_timer), .irq_external(irq_external),
    .irq_local(irq_local), .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .current_pc(current_pc), .instr_retire(instr_retire), .mret_exec(mret_exec),
    .trap_taken(trap_taken), .trap_pc(trap_pc), .mret_pc(mret_pc), .irq_pending(irq_pending)
  );

  // Reference model: architecturally visible CSR values.
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_mcycle, m_minstret;

  function automatic logic [31:0] ref_mip();
    logic [31:0] v;
    v = '0;
    v[3] = irq_software; v[7] = irq_timer; v[11] = irq_external;
    v[16 +: NL] = irq_local;
    return v;
  endfunction

  function automatic bit ref_ro(input logic [11:0] a);
    return a inside {12'h301, 12'h344, 12'hF14};
  endfunction

  function automatic bit ref_known(input logic [11:0] a);
    return ref_ro(a) || (a inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'h343, 12'hB00, 12'hB80, 12'hB02, 12'hB82});
  endfunction

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h301: return 32'h4000_0100;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return ref_mip();
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
      12'hB02: return m_minstret[31:0];
      12'hB82: return m_minstret[63:32];
      12'hF14: return HID;
      default: return 32'h0;
    endcase
  endfunction

  // Returns the winning interrupt code, or -1 when nothing enabled is pending.
  function automatic int ref_irq_code();
    int prio[NL+3];
    logic [31:0] pend;
    prio[0] = 11; prio[1] = 3; prio[2] = 7;
    for (int i = 0; i < NL; i++) prio[3+i] = 16 + i;
    pend = ref_mip() & m_mie;
    for (int k = 0; k < NL + 3; k++) if (pend[prio[k]]) return prio[k];
    return -1;
  endfunction

  function automatic bit ref_trap();
    return exc_valid || (m_mstatus[3] && ref_irq_code() >= 0);
  endfunction

  function automatic logic [31:0] ref_trap_pc();
    logic [31:0] base;
    base = m_mtvec & 32'hFFFF_FFFC;
    if (!exc_valid && m_mtvec[1:0] == 2'b01) return base + 32'(4 * ref_irq_code());
    return base;
  endfunction

  task automatic model_commit();
    logic [31:0] nv;
    bit trap, wr, old_mpie;
    int code;
    if (reset) begin
      m_mstatus = 32'h1800; m_mie = 0; m_mtvec = MT_RST; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mcycle = 0; m_minstret = 0;
      return;
    end
    trap = ref_trap();
    code = ref_irq_code();
    old_mpie = m_mstatus[7];
    wr = csr_wen && (csr_op inside {3'd1, 3'd2, 3'd3}) && ref_known(csr_addr) && !ref_ro(csr_addr) && !trap;
    case (csr_op)
      3'd2:    nv = ref_read(csr_addr) | csr_wdata;
      3'd3:    nv = ref_read(csr_addr) & ~csr_wdata;
      default: nv = csr_wdata;
    endcase
    if (wr && csr_addr == 12'hB00)      m_mcycle[31:0] = nv;
    else if (wr && csr_addr == 12'hB80) m_mcycle[63:32] = nv;
    else                                m_mcycle = m_mcycle + 1;
    if (wr && csr_addr == 12'hB02)      m_minstret[31:0] = nv;
    else if (wr && csr_addr == 12'hB82) m_minstret[63:32] = nv;
    else if (instr_retire)              m_minstret = m_minstret + 1;
    if (wr) begin
      case (csr_addr)
        12'h300: m_mstatus  = 32'h1800 | (nv & 32'h88);
        12'h304: m_mie      = nv & MIE_MSK;
        12'h305: m_mtvec    = nv & ~32'h2;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc     = nv & ~32'h3;
        12'h342: m_mcause   = nv;
        12'h343: m_mtval    = nv;
        default: ;
      endcase
    end
    if (trap) begin
      m_mepc    = current_pc & ~32'h3;
      m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      m_mcause  = exc_valid ? {28'd0, exc_cause} : (32'h8000_0000 | 32'(code));
      m_mtval   = exc_valid ? exc_tval : 32'h0;
    end else if (mret_exec) begin
      m_mstatus = 32'h1880 | (old_mpie ? 32'h8 : 32'h0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic peek(input logic [11:0] a, output logic [31:0] v);
    csr_addr = a;
    #1;
    v = csr_rdata;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [2:0] op, input logic [31:0] d);
    csr_addr = a; csr_op = op; csr_wdata = d; csr_wen = 1'b1;
    step();
    csr_wen = 1'b0; csr_op = 3'd0;
  endtask

  task automatic clear_inputs();
    csr_addr = 12'h340; csr_wdata = 0; csr_wen = 0; csr_op = 0;
    irq_software = 0; irq_timer = 0; irq_external = 0; irq_local = '0;
    exc_valid = 0; exc_cause = 0; exc_tval = 0; current_pc = 0;
    instr_retire = 0; mret_exec = 0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    clear_inputs();
    step();
    exc_valid = 1'b1; #1;
    n_checks++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL reset_trap_exc got=%b exp=1", trap_taken); end
    exc_valid = 1'b0; irq_timer = 1'b1; #1;
    n_checks++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL reset_trap_idle got=%b exp=0", trap_taken); end
    irq_timer = 1'b0;
    reset = 1'b0;
    peek(12'h300, v);
    n_checks++; if (v !== 32'h0000_1800) begin n_fail++; $display("FAIL reset_mstatus got=%h exp=00001800", v); end
    peek(12'h305, v);
    n_checks++; if (v !== MT_RST) begin n_fail++; $display("FAIL reset_mtvec got=%h exp=%h", v, MT_RST); end
    peek(12'h304, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mie got=%h exp=0", v); end
    peek(12'hB00, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mcycle got=%h exp=0", v); end
    peek(12'hF14, v);
    n_checks++; if (v !== 32'(HID)) begin n_fail++; $display("FAIL reset_mhartid got=%h exp=%h", v, HID); end
    peek(12'h301, v);
    n_checks++; if (v !== 32'h4000_0100) begin n_fail++; $display("FAIL reset_misa got=%h exp=40000100", v); end
    n_checks++; if (mret_pc !== 32'h0) begin n_fail++; $display("FAIL reset_mret_pc got=%h exp=0", mret_pc); end
  endtask

  task automatic test_timer_direct();
    logic [31:0] v;
    csr_write(12'h305, 3'd1, 32'h2000_0000);
    csr_write(12'h304, 3'd1, 32'h0000_0080);
    csr_write(12'h300, 3'd1, 32'h0000_0008);
    irq_timer = 1'b1; current_pc = 32'h1000_0000; #1;
    n_checks++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL timer_trap_taken got=%b exp=1", trap_taken); end
    n_checks++; if (trap_pc !== 32'h2000_0000) begin n_fail++; $display("FAIL timer_trap_pc got=%h exp=20000000", trap_pc); end
    step();
    #1;
    n_checks++; if (trap_taken !== 1'b0) begin n_fail++; $display("FAIL timer_masked_after got=%b exp=0", trap_taken); end
    n_checks++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL timer_irq_pending got=%b exp=1", irq_pending); end
    peek(12'h341, v);
    n_checks++; if (v !== 32'h1000_0000) begin n_fail++; $display("FAIL timer_mepc got=%h exp=10000000", v); end
    peek(12'h342, v);
    n_checks++; if (v !== 32'h8000_0007) begin n_fail++; $display("FAIL timer_mcause got=%h exp=80000007", v); end
    peek(12'h300, v);
    n_checks++; if (v !== 32'h0000_1880) begin n_fail++; $display("FAIL timer_mstatus got=%h exp=00001880", v); end
    irq_timer = 1'b0;
  endtask

  task automatic test_mret();
    logic [31:0] v;
    mret_exec = 1'b1; #1;
    n_checks++; if (mret_pc !== 32'h1000_0000) begin n_fail++; $display("FAIL mret_pc got=%h exp=10000000", mret_pc); end
    step();
    mret_exec = 1'b0;
    peek(12'h300, v);
    n_checks++; if (v !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_mstatus got=%h exp=00001888", v); end
  endtask

  task automatic test_vectored_priority();
    logic [31:0] v;
    csr_write(12'h305, 3'd1, 32'h3000_0001);
    csr_write(12'h304, 3'd1, 32'h0001_0888);
    irq_timer = 1'b1; irq_external = 1'b1; irq_local = 4'b0001; current_pc = 32'h1000_0040; #1;
    n_checks++; if (trap_pc !== 32'h3000_002C) begin n_fail++; $display("FAIL vec_mei_trap_pc got=%h exp=3000002C", trap_pc); end
    step();
    peek(12'h342, v);
    n_checks++; if (v !== 32'h8000_000B) begin n_fail++; $display("FAIL vec_mei_mcause got=%h exp=8000000B", v); end
    mret_exec = 1'b1;
    step();
    mret_exec = 1'b0; irq_external = 1'b0; irq_timer = 1'b0; #1;
    n_checks++; if (trap_pc !== 32'h3000_0040) begin n_fail++; $display("FAIL vec_local_trap_pc got=%h exp=30000040", trap_pc); end
    step();
    peek(12'h342, v);
    n_checks++; if (v !== 32'h8000_0010) begin n_fail++; $display("FAIL vec_local_mcause got=%h exp=80000010", v); end
    irq_local = '0;
  endtask

  task automatic test_exception();
    logic [31:0] v;
    exc_valid = 1'b1; exc_cause = 4'd2; exc_tval = 32'hDEAD_BEEF; current_pc = 32'h1000_0100; #1;
    n_checks++; if (trap_taken !== 1'b1) begin n_fail++; $display("FAIL exc_trap_taken got=%b exp=1", trap_taken); end
    n_checks++; if (trap_pc !== 32'h3000_0000) begin n_fail++; $display("FAIL exc_trap_pc got=%h exp=30000000", trap_pc); end
    step();
    exc_valid = 1'b0;
    peek(12'h342, v);
    n_checks++; if (v !== 32'h0000_0002) begin n_fail++; $display("FAIL exc_mcause got=%h exp=2", v); end
    peek(12'h343, v);
    n_checks++; if (v !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL exc_mtval got=%h exp=DEADBEEF", v); end
    csr_write(12'h300, 3'd1, 32'h0000_0008);
    exc_valid = 1'b1; exc_tval = 32'h0000_1234; irq_timer = 1'b1; #1;
    n_checks++; if (trap_pc !== 32'h3000_0000) begin n_fail++; $display("FAIL exc_irq_trap_pc got=%h exp=30000000", trap_pc); end
    step();
    exc_valid = 1'b0; irq_timer = 1'b0;
    peek(12'h342, v);
    n_checks++; if (v !== 32'h0000_0002) begin n_fail++; $display("FAIL exc_irq_mcause got=%h exp=2", v); end
    csr_write(12'h300, 3'd1, 32'h0000_0008);
    irq_timer = 1'b1; #1;
    n_checks++; if (trap_pc !== 32'h3000_001C) begin n_fail++; $display("FAIL mti_vec_trap_pc got=%h exp=3000001C", trap_pc); end
    step();
    irq_timer = 1'b0;
    peek(12'h343, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL irq_mtval_zero got=%h exp=0", v); end
  endtask

  task automatic test_csr_ops();
    logic [31:0] v;
    csr_write(12'h340, 3'd1, 32'h0000_F0F0);
    peek(12'h340, v);
    n_checks++; if (v !== 32'h0000_F0F0) begin n_fail++; $display("FAIL op_rw got=%h exp=F0F0", v); end
    n_checks++; if (csr_illegal !== 1'b0) begin n_fail++; $display("FAIL op_legal got=%b exp=0", csr_illegal); end
    csr_write(12'h340, 3'd2, 32'h0000_000F);
    peek(12'h340, v);
    n_checks++; if (v !== 32'h0000_F0FF) begin n_fail++; $display("FAIL op_rs got=%h exp=F0FF", v); end
    csr_write(12'h340, 3'd3, 32'h0000_00F0);
    peek(12'h340, v);
    n_checks++; if (v !== 32'h0000_F00F) begin n_fail++; $display("FAIL op_rc got=%h exp=F00F", v); end
    irq_software = 1'b1;
    csr_addr = 12'h344; csr_op = 3'd1; csr_wdata = 32'hFFFF_FFFF; csr_wen = 1'b1; #1;
    n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL mip_write_illegal got=%b exp=1", csr_illegal); end
    step();
    csr_wen = 1'b0; csr_op = 3'd0;
    peek(12'h344, v);
    n_checks++; if (v !== 32'h0000_0008) begin n_fail++; $display("FAIL mip_value got=%h exp=8", v); end
    irq_software = 1'b0;
    peek(12'h7C0, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL unimpl_read got=%h exp=0", v); end
    n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL unimpl_illegal got=%b exp=1", csr_illegal); end
    csr_write(12'h305, 3'd1, 32'h3000_0003);
    peek(12'h305, v);
    n_checks++; if (v !== 32'h3000_0001) begin n_fail++; $display("FAIL mtvec_warl got=%h exp=30000001", v); end
  endtask

  task automatic test_counters();
    logic [31:0] v;
    csr_write(12'hB00, 3'd1, 32'hFFFF_FFFE);
    csr_write(12'hB80, 3'd1, 32'hFFFF_FFFF);
    step(); step();
    peek(12'hB00, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap_lo got=%h exp=0", v); end
    peek(12'hB80, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL mcycle_wrap_hi got=%h exp=0", v); end
    csr_write(12'hB02, 3'd1, 32'h0);
    csr_write(12'hB82, 3'd1, 32'h0);
    instr_retire = 1'b1;
    step(); step(); step();
    instr_retire = 1'b0;
    peek(12'hB02, v);
    n_checks++; if (v !== 32'h3) begin n_fail++; $display("FAIL minstret_count got=%h exp=3", v); end
  endtask

  task automatic test_trap_collisions();
    logic [31:0] v;
    exc_valid = 1'b1; exc_cause = 4'd5; current_pc = 32'h0000_0044;
    csr_addr = 12'h340; csr_op = 3'd1; csr_wdata = 32'h0000_1111; csr_wen = 1'b1;
    step();
    csr_wen = 1'b0;
    peek(12'h340, v);
    n_checks++; if (v !== 32'h0000_F00F) begin n_fail++; $display("FAIL trap_write_discard got=%h exp=F00F", v); end
    csr_addr = 12'h344; csr_wen = 1'b1; #1;
    n_checks++; if (csr_illegal !== 1'b1) begin n_fail++; $display("FAIL trap_illegal_kept got=%b exp=1", csr_illegal); end
    csr_wen = 1'b0; csr_op = 3'd0;
    mret_exec = 1'b1; current_pc = 32'h0000_0088;
    step();
    mret_exec = 1'b0; exc_valid = 1'b0;
    peek(12'h341, v);
    n_checks++; if (v !== 32'h0000_0088) begin n_fail++; $display("FAIL trap_mret_mepc got=%h exp=88", v); end
    peek(12'h300, v);
    n_checks++; if (v !== 32'h0000_1800) begin n_fail++; $display("FAIL trap_mret_mstatus got=%h exp=1800", v); end
  endtask

  task automatic test_random();
    logic [11:0] addrs [16];
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h000};
    for (int n = 0; n < 400; n++) begin
      reset        = ($urandom_range(0, 99) == 0);
      csr_addr     = addrs[$urandom_range(0, 15)];
      csr_op       = 3'($urandom_range(0, 7));
      csr_wen      = 1'($urandom_range(0, 1));
      csr_wdata    = $urandom;
      irq_software = ($urandom_range(0, 3) == 0);
      irq_timer    = ($urandom_range(0, 3) == 0);
      irq_external = ($urandom_range(0, 3) == 0);
      irq_local    = NL'($urandom & $urandom);
      exc_valid    = ($urandom_range(0, 15) == 0);
      exc_cause    = 4'($urandom);
      exc_tval     = $urandom;
      current_pc   = $urandom;
      instr_retire = 1'($urandom_range(0, 1));
      mret_exec    = ($urandom_range(0, 7) == 0);
      #1;
      n_checks++; if (csr_rdata !== ref_read(csr_addr)) begin n_fail++; $display("FAIL rnd_rdata addr=%h got=%h exp=%h", csr_addr, csr_rdata, ref_read(csr_addr)); end
      n_checks++; if (csr_illegal !== (!ref_known(csr_addr) || (ref_ro(csr_addr) && csr_wen && (csr_op inside {3'd1, 3'd2, 3'd3}))))
        begin n_fail++; $display("FAIL rnd_illegal addr=%h got=%b", csr_addr, csr_illegal); end
      n_checks++; if (trap_taken !== ref_trap()) begin n_fail++; $display("FAIL rnd_trap_taken got=%b exp=%b", trap_taken, ref_trap()); end
      if (ref_trap()) begin
        n_checks++; if (trap_pc !== ref_trap_pc()) begin n_fail++; $display("FAIL rnd_trap_pc got=%h exp=%h", trap_pc, ref_trap_pc()); end
      end
      n_checks++; if (mret_pc !== m_mepc) begin n_fail++; $display("FAIL rnd_mret_pc got=%h exp=%h", mret_pc, m_mepc); end
      n_checks++; if (irq_pending !== ((ref_mip() & m_mie) != 0)) begin n_fail++; $display("FAIL rnd_irq_pending got=%b", irq_pending); end
      step();
    end
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_timer_direct();
    test_mret();
    test_vectored_priority();
    test_exception();
    test_csr_ops();
    test_counters();
    test_trap_collisions();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
